// File: rtl/exe_stage.sv
// Execute stage: ALU, single-cycle multiplier, iterative restoring divider,
// valid/allowin pipeline handshake, data SRAM request and ID bypass.
module exe_stage #(
   parameter int unsigned ID_TO_EXE_BUS_WD  = 144,
   parameter int unsigned EXE_TO_MEM_BUS_WD = 72
) (
   input  logic                         clk,
   input  logic                         resetn,
   output logic                         exe_allowin,
   input  logic                         mem_allowin,
   input  logic                         id_to_exe_valid,
   input  logic [ID_TO_EXE_BUS_WD-1:0]  id_to_exe_bus,
   output logic                         exe_to_mem_valid,
   output logic [EXE_TO_MEM_BUS_WD-1:0] exe_to_mem_bus,
   output logic                         data_sram_en,
   output logic [3:0]                   data_sram_wen,
   output logic [31:0]                  data_sram_addr,
   output logic [31:0]                  data_sram_wdata,
   output logic [31:0]                  exe_to_id_bypass,
   output logic [4:0]                   exe_to_id_rdbypass,
   output logic                         exe_to_id_rfwenbypass,
   output logic                         exe_to_id_loadbypass,
   output logic                         exe_to_id_readybypass
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } div_state_t;

   // pipeline registers
   logic                        r_exe_valid;
   logic [ID_TO_EXE_BUS_WD-1:0] r_bus;

   // divider state
   div_state_t       r_state;
   div_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [XLEN-1:0]  r_rem;
   logic [XLEN-1:0]  r_quo;
   logic [XLEN-1:0]  r_dvsr;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_dvz;

   // decoded bus fields
   logic [3:0]      w_alu_op;
   logic [2:0]      w_md_op;
   logic [XLEN-1:0] w_src1;
   logic [XLEN-1:0] w_src2;
   logic [XLEN-1:0] w_store_data;
   logic            w_mem_we;
   logic            w_mem_load;
   logic            w_dst_wb;
   logic [4:0]      w_rd;
   logic [XLEN-1:0] w_pc;
   logic            w_ebreak;

   assign w_alu_op     = r_bus[143:140];
   assign w_md_op      = r_bus[139:137];
   assign w_src1       = r_bus[136:105];
   assign w_src2       = r_bus[104:73];
   assign w_store_data = r_bus[72:41];
   assign w_mem_we     = r_bus[40];
   assign w_mem_load   = r_bus[39];
   assign w_dst_wb     = r_bus[38];
   assign w_rd         = r_bus[37:33];
   assign w_pc         = r_bus[32:1];
   assign w_ebreak     = r_bus[0];

   logic w_is_div;
   logic w_is_rem;
   logic w_signed_div;
   logic w_ready_go;
   logic w_handoff;
   logic w_div_start;

   assign w_is_div     = w_md_op[2];
   assign w_is_rem     = w_md_op[1];
   assign w_signed_div = w_md_op[2] & ~w_md_op[0];
   assign w_ready_go   = !w_is_div || (r_state == S_DONE);
   assign w_handoff    = exe_to_mem_valid && mem_allowin;
   assign w_div_start  = r_exe_valid && w_is_div;

   assign exe_allowin      = !r_exe_valid || (w_ready_go && mem_allowin);
   assign exe_to_mem_valid = r_exe_valid && w_ready_go;

   // valid bit of the stage; cleared asynchronously so reset discards work in flight
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_exe_valid <= 1'b0;
      end else if (exe_allowin) begin
         r_exe_valid <= id_to_exe_valid;
      end
   end

   // instruction payload; contents are meaningless while the stage is empty
   always_ff @(posedge clk) begin
      if (exe_allowin && id_to_exe_valid) begin
         r_bus <= id_to_exe_bus;
      end
   end

   // ALU
   logic [XLEN-1:0] w_alu_res;
   always_comb begin
      w_alu_res = '0;
      case (w_alu_op)
         4'd0:    w_alu_res = w_src1 + w_src2;
         4'd1:    w_alu_res = w_src1 - w_src2;
         4'd2:    w_alu_res = {31'b0, ($signed(w_src1) < $signed(w_src2))};
         4'd3:    w_alu_res = {31'b0, (w_src1 < w_src2)};
         4'd4:    w_alu_res = w_src1 & w_src2;
         4'd5:    w_alu_res = w_src1 | w_src2;
         4'd6:    w_alu_res = w_src1 ^ w_src2;
         4'd7:    w_alu_res = w_src1 << w_src2[4:0];
         4'd8:    w_alu_res = w_src1 >> w_src2[4:0];
         4'd9:    w_alu_res = XLEN'($signed(w_src1) >>> w_src2[4:0]);
         4'd10:   w_alu_res = w_src2;
         default: w_alu_res = '0;
      endcase
   end

   // single-cycle multiplier, signed and unsigned full products
   logic [2*XLEN-1:0] w_prod_s;
   logic [2*XLEN-1:0] w_prod_u;
   assign w_prod_s = $signed({{XLEN{w_src1[XLEN-1]}}, w_src1}) *
                     $signed({{XLEN{w_src2[XLEN-1]}}, w_src2});
   assign w_prod_u = {{XLEN{1'b0}}, w_src1} * {{XLEN{1'b0}}, w_src2};

   // operand magnitudes for the unsigned restoring core
   logic [XLEN-1:0] w_abs1;
   logic [XLEN-1:0] w_abs2;
   assign w_abs1 = (w_signed_div && w_src1[XLEN-1]) ? XLEN'(-w_src1) : w_src1;
   assign w_abs2 = (w_signed_div && w_src2[XLEN-1]) ? XLEN'(-w_src2) : w_src2;

   // one restoring step: shift in next dividend bit, subtract if it fits
   logic [XLEN:0] w_shift;
   logic [XLEN:0] w_diff;
   assign w_shift = {r_rem, r_quo[XLEN-1]};
   assign w_diff  = w_shift - {1'b0, r_dvsr};

   // divider state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // divider next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_div_start) w_state_nxt = S_BUSY;
         S_BUSY:  if (r_cnt == CNT_W'(XLEN - 1)) w_state_nxt = S_DONE;
         S_DONE:  if (w_handoff) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // divider datapath: latch operands on start, iterate while busy
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt   <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_dvsr  <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dvz   <= 1'b0;
      end else if (r_state == S_IDLE && w_div_start) begin
         r_cnt   <= '0;
         r_rem   <= '0;
         r_quo   <= w_abs1;
         r_dvsr  <= w_abs2;
         r_neg_q <= w_signed_div && (w_src1[XLEN-1] ^ w_src2[XLEN-1]);
         r_neg_r <= w_signed_div && w_src1[XLEN-1];
         r_dvz   <= (w_src2 == '0);
      end else if (r_state == S_BUSY) begin
         r_cnt <= r_cnt + CNT_W'(1);
         if (!w_diff[XLEN]) begin
            r_rem <= w_diff[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], 1'b1};
         end else begin
            r_rem <= w_shift[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], 1'b0};
         end
      end
   end

   // sign fix-up; a zero divisor yields all-ones quotient regardless of signs
   logic [XLEN-1:0] w_quo_fix;
   logic [XLEN-1:0] w_rem_fix;
   assign w_quo_fix = r_dvz ? '1 : (r_neg_q ? XLEN'(-r_quo) : r_quo);
   assign w_rem_fix = r_neg_r ? XLEN'(-r_rem) : r_rem;

   // final result mux
   logic [XLEN-1:0] w_result;
   always_comb begin
      w_result = w_alu_res;
      case (w_md_op)
         3'd0:    w_result = w_alu_res;
         3'd1:    w_result = w_prod_u[XLEN-1:0];
         3'd2:    w_result = w_prod_s[2*XLEN-1:XLEN];
         3'd3:    w_result = w_prod_u[2*XLEN-1:XLEN];
         default: w_result = w_is_rem ? w_rem_fix : w_quo_fix;
      endcase
   end

   assign exe_to_mem_bus = {w_mem_load, w_dst_wb, w_result, w_rd, w_pc, w_ebreak};

   // memory request fires only on the handoff cycle so a stall never repeats it
   assign data_sram_en    = r_exe_valid && (w_mem_load || w_mem_we) && w_ready_go && mem_allowin;
   assign data_sram_wen   = (data_sram_en && w_mem_we) ? 4'hF : 4'h0;
   assign data_sram_addr  = w_result;
   assign data_sram_wdata = w_store_data;

   assign exe_to_id_bypass      = w_result;
   assign exe_to_id_rdbypass    = w_rd;
   assign exe_to_id_rfwenbypass = r_exe_valid && w_dst_wb;
   assign exe_to_id_loadbypass  = r_exe_valid && w_mem_load;
   assign exe_to_id_readybypass = r_exe_valid && w_ready_go && !w_mem_load;

endmodule

// File: tb/tb_exe_stage.sv
// Randomized scoreboard bench for exe_stage with directed corner cases.
module tb_exe_stage;

   logic         clk;
   logic         resetn;
   logic         exe_allowin;
   logic         mem_allowin;
   logic         id_to_exe_valid;
   logic [143:0] id_to_exe_bus;
   logic         exe_to_mem_valid;
   logic [71:0]  exe_to_mem_bus;
   logic         data_sram_en;
   logic [3:0]   data_sram_wen;
   logic [31:0]  data_sram_addr;
   logic [31:0]  data_sram_wdata;
   logic [31:0]  exe_to_id_bypass;
   logic [4:0]   exe_to_id_rdbypass;
   logic         exe_to_id_rfwenbypass;
   logic         exe_to_id_loadbypass;
   logic         exe_to_id_readybypass;

   exe_stage dut (
      .clk                   (clk),
      .resetn                (resetn),
      .exe_allowin           (exe_allowin),
      .mem_allowin           (mem_allowin),
      .id_to_exe_valid       (id_to_exe_valid),
      .id_to_exe_bus         (id_to_exe_bus),
      .exe_to_mem_valid      (exe_to_mem_valid),
      .exe_to_mem_bus        (exe_to_mem_bus),
      .data_sram_en          (data_sram_en),
      .data_sram_wen         (data_sram_wen),
      .data_sram_addr        (data_sram_addr),
      .data_sram_wdata       (data_sram_wdata),
      .exe_to_id_bypass      (exe_to_id_bypass),
      .exe_to_id_rdbypass    (exe_to_id_rdbypass),
      .exe_to_id_rfwenbypass (exe_to_id_rfwenbypass),
      .exe_to_id_loadbypass  (exe_to_id_loadbypass),
      .exe_to_id_readybypass (exe_to_id_readybypass)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [71:0] bus;
      logic [31:0] result;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic        we;
      logic        ld;
      logic        wb;
      int          t;
      int          lat;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   en_pulses = 0;
   bit   rand_mem = 1'b0;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // behavioural reference result from opcode rules and plain arithmetic
   function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [2:0] md,
                                              input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, sp;
      longint unsigned ua, ub, up;
      int              ia, ib;
      logic [4:0]      sh;
      sh = b[4:0];
      sa = $signed(a);
      sb = $signed(b);
      sp = sa * sb;
      ua = a;
      ub = b;
      up = ua * ub;
      ia = a;
      ib = b;
      case (md)
         3'd1: return up[31:0];
         3'd2: return sp[63:32];
         3'd3: return up[63:32];
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return ia / ib;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return ia % ib;
         end
         3'd7: return (b == 0) ? a : a % b;
         default: begin
            case (op)
               4'd0:    return a + b;
               4'd1:    return a - b;
               4'd2:    return (sa < sb) ? 32'd1 : 32'd0;
               4'd3:    return (a < b) ? 32'd1 : 32'd0;
               4'd4:    return a & b;
               4'd5:    return a | b;
               4'd6:    return a ^ b;
               4'd7:    return a << sh;
               4'd8:    return a >> sh;
               4'd9:    return 32'($signed(a) >>> sh);
               4'd10:   return b;
               default: return 32'h0;
            endcase
         end
      endcase
   endfunction

   // present one instruction until accepted, then record what MEM must see
   task automatic send(input logic [3:0] op, input logic [2:0] md, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] sd, input logic we,
                       input logic ld, input logic wb, input logic [4:0] rd,
                       input logic [31:0] pc, input logic eb);
      exp_t e;
      bit   acc;
      int   n;
      id_to_exe_bus   = {op, md, a, b, sd, we, ld, wb, rd, pc, eb};
      id_to_exe_valid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 300) begin
         @(negedge clk);
         acc = exe_allowin;
         @(posedge clk);
         #1;
         n++;
      end
      id_to_exe_valid = 1'b0;
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got allowin=0 for %0d cycles expected acceptance", n);
      end else begin
         e.result = ref_result(op, md, a, b);
         e.bus    = {ld, wb, e.result, rd, pc, eb};
         e.wdata  = sd;
         e.rd     = rd;
         e.we     = we;
         e.ld     = ld;
         e.wb     = wb;
         e.t      = cyc + 1;
         e.lat    = (md >= 3'd4) ? 33 : 0;
         q.push_back(e);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
         q.delete();
      end
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom % 6)
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom % 16);
         default: return $urandom;
      endcase
   endfunction

   // random MEM backpressure
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_mem) mem_allowin = (($urandom % 4) != 0);
      end
   end

   // monitor: every cycle compare visible state against the head of the scoreboard
   initial begin
      exp_t e;
      bit   ev;
      bit   en_exp;
      forever begin
         @(negedge clk);
         if (resetn) begin
            cyc++;
            if (data_sram_en) en_pulses++;
            if (q.size() > 0) begin
               e = q[0];
               ev = (cyc >= e.t + e.lat);
               en_exp = ev && mem_allowin && (e.ld || e.we);
               chk("to_mem_valid", 72'(exe_to_mem_valid), 72'(ev));
               chk("allowin", 72'(exe_allowin), 72'(ev && mem_allowin));
               chk("rfwen_bypass", 72'(exe_to_id_rfwenbypass), 72'(e.wb));
               chk("load_bypass", 72'(exe_to_id_loadbypass), 72'(e.ld));
               chk("rd_bypass", 72'(exe_to_id_rdbypass), 72'(e.rd));
               chk("ready_bypass", 72'(exe_to_id_readybypass), 72'(ev && !e.ld));
               chk("sram_en", 72'(data_sram_en), 72'(en_exp));
               if (en_exp) begin
                  chk("sram_wen", 72'(data_sram_wen), e.we ? 72'hF : 72'h0);
                  chk("sram_addr", 72'(data_sram_addr), 72'(e.result));
                  if (e.we) chk("sram_wdata", 72'(data_sram_wdata), 72'(e.wdata));
               end
               if (ev) begin
                  chk("to_mem_bus", exe_to_mem_bus, e.bus);
                  chk("bypass_value", 72'(exe_to_id_bypass), 72'(e.result));
                  if (mem_allowin) void'(q.pop_front());
               end
            end else begin
               chk("idle_valid", 72'(exe_to_mem_valid), 72'h0);
               chk("idle_allowin", 72'(exe_allowin), 72'h1);
               chk("idle_sram_en", 72'(data_sram_en), 72'h0);
               chk("idle_rfwen", 72'(exe_to_id_rfwenbypass), 72'h0);
               chk("idle_load", 72'(exe_to_id_loadbypass), 72'h0);
            end
         end
      end
   end

   initial begin
      int p;
      logic [2:0] md;
      logic [1:0] mk;
      resetn          = 1'b0;
      mem_allowin     = 1'b0;
      id_to_exe_valid = 1'b0;
      id_to_exe_bus   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", 72'(exe_to_mem_valid), 72'h0);
      chk("reset_allowin", 72'(exe_allowin), 72'h1);
      chk("reset_sram_en", 72'(data_sram_en), 72'h0);
      chk("reset_sram_wen", 72'(data_sram_wen), 72'h0);
      chk("reset_flags", 72'({exe_to_id_rfwenbypass, exe_to_id_loadbypass, exe_to_id_readybypass}), 72'h0);
      @(posedge clk);
      #3;
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // directed arithmetic and divide corners, no backpressure
      mem_allowin = 1'b1;
      send(4'd0, 3'd0, 32'd5, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h1000, 1'b0);
      send(4'd0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'h0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h1004, 1'b0);
      send(4'd0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1008, 1'b0);
      send(4'd0, 3'd5, 32'h1234, 32'd0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd6, 32'h100C, 1'b0);
      send(4'd0, 3'd7, 32'h1234, 32'd0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h1010, 1'b0);
      send(4'd0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b1, 5'd8, 32'h1014, 1'b1);
      send(4'd0, 3'd4, 32'hFFFF_FFF9, 32'd0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h1018, 1'b0);
      drain();

      // store held off by MEM for three cycles: request must fire once
      mem_allowin = 1'b0;
      p = en_pulses;
      send(4'd0, 3'd0, 32'h100, 32'h24, 32'hCAFE_BABE, 1'b1, 1'b0, 1'b0, 5'd0, 32'h2000, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      mem_allowin = 1'b1;
      drain();
      repeat (2) @(posedge clk);
      #1;
      chk("store_en_pulses", 72'(en_pulses - p), 72'd1);

      // finished divide stalled five cycles in DONE
      mem_allowin = 1'b0;
      send(4'd0, 3'd4, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 1'b1, 5'd10, 32'h3000, 1'b0);
      repeat (38) @(posedge clk);
      #1;
      mem_allowin = 1'b1;
      drain();
      send(4'd0, 3'd7, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 1'b1, 5'd11, 32'h3004, 1'b0);
      drain();

      // reset in the middle of a divide, then multiplies right after release
      send(4'd0, 3'd5, 32'h1234_5678, 32'd3, 32'h0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h4000, 1'b0);
      repeat (11) @(posedge clk);
      #1;
      resetn = 1'b0;
      #1;
      chk("midreset_valid", 72'(exe_to_mem_valid), 72'h0);
      chk("midreset_allowin", 72'(exe_allowin), 72'h1);
      chk("midreset_flags", 72'({exe_to_id_rfwenbypass, exe_to_id_readybypass, data_sram_en}), 72'h0);
      q.delete();
      @(posedge clk);
      #3;
      resetn = 1'b1;
      @(posedge clk);
      #1;
      send(4'd0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b1, 5'd13, 32'h5000, 1'b0);
      send(4'd0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b1, 5'd14, 32'h5004, 1'b0);
      send(4'd0, 3'd6, 32'hFFFF_FF00, 32'd7, 32'h0, 1'b0, 1'b0, 1'b1, 5'd15, 32'h5008, 1'b0);
      drain();

      // randomized traffic with random backpressure
      rand_mem = 1'b1;
      for (int i = 0; i < 150; i++) begin
         md = (($urandom % 4) == 0) ? 3'(4 + ($urandom % 4)) : 3'($urandom % 4);
         mk = 2'($urandom % 4);
         send(4'($urandom % 16), md, pick_operand(), pick_operand(), $urandom,
              mk == 2'd1, mk == 2'd2, 1'($urandom % 2), 5'($urandom % 32),
              $urandom, 1'($urandom % 2));
         repeat ($urandom % 3) begin
            @(posedge clk);
            #1;
         end
      end
      drain();
      rand_mem = 1'b0;
      mem_allowin = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
